// File: rtl/memdump.sv
// -----------------------------------------------------------------------------
// memdump -- memory reader/dumper
//
// Purpose:
//   On a start pulse, reads WORDS 16-bit words from address 0 upward over the
//   memory rd/wait port. Each word goes out over the uart transmitter
//   start/wait interface as one text line. The line is four uppercase ASCII
//   hex digits, most significant nibble first, followed by CR LF.
//   This block is the read-side counterpart of the boot-time memory
//   initialiser. While o_busy is high, the top level muxes o_memaddr/o_memrd
//   onto the memory.
//
// Optional feature (macro MEMDUMP_ADDR_EN):
//   When defined, each line is prefixed with the word address: four hex
//   digits (zero-extended to 16 bits), then ':' and ' '. That gives 12 bytes
//   per line instead of 6. When undefined, the address formatting logic is
//   not built.
//
// Parameters:
//   ABITS  memory address width
//   WORDS  words dumped per run, 1..2**ABITS
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     1-cycle pulse, begin a dump (ignored while busy)
//   o_busy      high from accepted start until the done cycle inclusive
//   o_done      1-cycle pulse after the last byte is accepted
//   o_memrd     read request, held until i_memwait is low
//   i_memwait   memory busy; i_memrdata valid when o_memrd=1 and i_memwait=0
//   o_memaddr   read address
//   i_memrdata  read data
//   o_txdata    byte to transmit, valid while o_txstart=1
//   o_txstart   1-cycle transmit pulse, only when i_txwait=0
//   i_txwait    transmitter busy
// -----------------------------------------------------------------------------
module memdump #(
  parameter int ABITS = 9,
  parameter int WORDS = 2**ABITS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_memrd,
  input  logic             i_memwait,
  output logic [ABITS-1:0] o_memaddr,
  input  logic [15:0]      i_memrdata,
  output logic [7:0]       o_txdata,
  output logic             o_txstart,
  input  logic             i_txwait
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_TX,
    S_HOLD,
    S_NEXT,
    S_DONE
  } state_t;

  // One extra address bit so that WORDS = 2**ABITS terminates at all-ones
  // instead of wrapping back to zero.
  localparam logic [ABITS:0] LAST_ADDR = (ABITS+1)'(WORDS-1);

`ifdef MEMDUMP_ADDR_EN
  localparam logic [3:0] LAST_IDX = 4'd11;
`else
  localparam logic [3:0] LAST_IDX = 4'd5;
`endif

  state_t         r_state;
  state_t         w_nextState;
  logic [ABITS:0] r_addr;
  logic [15:0]    r_word;
  logic [3:0]     r_idx;
  logic           r_holdArmed;
  logic [7:0]     w_char;
  logic           w_lineEnd;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_lineEnd = (r_idx == LAST_IDX);

`ifdef MEMDUMP_ADDR_EN
  logic [15:0] w_addr16;
  assign w_addr16 = 16'(r_addr[ABITS-1:0]);
`endif

  // Character generator: byte r_idx of the current line.
  always_comb begin
    w_char = 8'h00;
`ifdef MEMDUMP_ADDR_EN
    case (r_idx)
      4'd0:    w_char = hexChar(w_addr16[15:12]);
      4'd1:    w_char = hexChar(w_addr16[11:8]);
      4'd2:    w_char = hexChar(w_addr16[7:4]);
      4'd3:    w_char = hexChar(w_addr16[3:0]);
      4'd4:    w_char = 8'h3A;
      4'd5:    w_char = 8'h20;
      4'd6:    w_char = hexChar(r_word[15:12]);
      4'd7:    w_char = hexChar(r_word[11:8]);
      4'd8:    w_char = hexChar(r_word[7:4]);
      4'd9:    w_char = hexChar(r_word[3:0]);
      4'd10:   w_char = 8'h0D;
      4'd11:   w_char = 8'h0A;
      default: w_char = 8'h00;
    endcase
`else
    case (r_idx)
      4'd0:    w_char = hexChar(r_word[15:12]);
      4'd1:    w_char = hexChar(r_word[11:8]);
      4'd2:    w_char = hexChar(r_word[7:4]);
      4'd3:    w_char = hexChar(r_word[3:0]);
      4'd4:    w_char = 8'h0D;
      4'd5:    w_char = 8'h0A;
      default: w_char = 8'h00;
    endcase
`endif
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (i_start)    w_nextState = S_RD;
      S_RD:   if (!i_memwait) w_nextState = S_TX;
      S_TX:   if (!i_txwait)  w_nextState = S_HOLD;
      S_HOLD: begin
        // The first HOLD cycle is blind to i_txwait because the transmitter
        // needs one cycle to raise it after seeing o_txstart.
        if (r_holdArmed && !i_txwait) begin
          w_nextState = w_lineEnd ? S_NEXT : S_TX;
        end
      end
      S_NEXT: w_nextState = (r_addr == LAST_ADDR) ? S_DONE : S_RD;
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath registers: address counter, captured word, char index, hold flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      r_holdArmed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) r_addr <= '0;
        S_RD: begin
          if (!i_memwait) begin
            r_word <= i_memrdata;
            r_idx  <= '0;
          end
        end
        S_TX: if (!i_txwait) r_holdArmed <= 1'b0;
        S_HOLD: begin
          if (!r_holdArmed) begin
            r_holdArmed <= 1'b1;
          end else if (!i_txwait && !w_lineEnd) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_NEXT: if (r_addr != LAST_ADDR) r_addr <= r_addr + (ABITS+1)'(1);
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the state. Gating o_txstart with i_txwait lets
  // a byte leave in the same cycle the transmitter frees up.
  always_comb begin
    o_busy    = (r_state != S_IDLE);
    o_done    = (r_state == S_DONE);
    o_memrd   = (r_state == S_RD);
    o_memaddr = r_addr[ABITS-1:0];
    o_txstart = (r_state == S_TX) && !i_txwait;
    o_txdata  = (r_state == S_TX) ? w_char : 8'h00;
  end

endmodule

// File: tb/tb_memdump.sv
// -----------------------------------------------------------------------------
// tb_memdump -- self-checking bench for memdump
//
// Purpose:
//   Drives memdump with a memory model (random wait states and a forced stall)
//   and a transmitter model (random busy times). Every transmitted byte is
//   checked against text built directly from the memory contents. The bench
//   also checks the read address sequence, the done pulse, ignored starts,
//   and abort on reset.
//   Honours MEMDUMP_ADDR_EN for the expected line format.
// -----------------------------------------------------------------------------
module tb_memdump;

  localparam int ABITS     = 3;
  localparam int WORDS     = 8;
  localparam int CYC_LIMIT = 60000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             memwait = 1'b0;
  logic             txwait = 1'b0;
  logic             busy;
  logic             done;
  logic             memrd;
  logic             txstart;
  logic [ABITS-1:0] memaddr;
  logic [15:0]      memrdata;
  logic [7:0]       txdata;

  logic [15:0] mem [WORDS];

  int testsRun    = 0;
  int testsFailed = 0;

  byte unsigned rxQ[$];
  byte unsigned expQ[$];

  int txMax       = 4;
  bit txJitter    = 1'b0;
  int txBusy      = 0;
  int stallAddr   = 1;
  int stallLeft   = 0;
  bit stallActive = 1'b0;
  int doneCount   = 0;
  int readCount   = 0;
  int expReadAddr = 0;

  memdump #(.ABITS(ABITS), .WORDS(WORDS)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_memrd    (memrd),
    .i_memwait  (memwait),
    .o_memaddr  (memaddr),
    .i_memrdata (memrdata),
    .o_txdata   (txdata),
    .o_txstart  (txstart),
    .i_txwait   (txwait)
  );

  initial forever #5 clk = ~clk;

  assign memrdata = mem[memaddr];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected text of one line, straight from the output format rules.
  task automatic pushLine(input int a, input logic [15:0] w);
    string hexDigits = "0123456789ABCDEF";
`ifdef MEMDUMP_ADDR_EN
    for (int s = 12; s >= 0; s -= 4) expQ.push_back(hexDigits[(a >> s) & 15]);
    expQ.push_back(8'h3A);
    expQ.push_back(8'h20);
`endif
    for (int s = 12; s >= 0; s -= 4) expQ.push_back(hexDigits[(int'(w) >> s) & 15]);
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
  endtask

  task automatic buildExpected();
    expQ.delete();
    for (int a = 0; a < WORDS; a++) pushLine(a, mem[a]);
  endtask

  // Memory model: random wait states, plus an optional stall of stallLeft
  // cycles on the first read of stallAddr.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      memwait     = 1'b0;
      stallActive = 1'b0;
    end else if (stallLeft > 0 && (stallActive || (memrd && int'(memaddr) == stallAddr))) begin
      if (stallActive) begin
        checkOutput("stall_memrd", 32'(memrd), 32'd1);
        checkOutput("stall_addr", 32'(memaddr), 32'(stallAddr));
        checkOutput("stall_txstart", 32'(txstart), 32'd0);
      end
      stallActive = 1'b1;
      memwait     = 1'b1;
      stallLeft--;
    end else begin
      stallActive = 1'b0;
      memwait     = ($urandom_range(0, 3) == 0);
    end
  end

  // Transmitter model: busy for a random 1..txMax cycles after each byte.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      txBusy = 0;
      txwait = 1'b0;
    end else begin
      if (txBusy > 0) begin
        txwait = 1'b1;
        txBusy--;
      end else begin
        txwait = txJitter && ($urandom_range(0, 3) == 0);
      end
      #1;
      if (rst_n && txstart) begin
        checkOutput("txstart_while_wait", 32'(txwait), 32'd0);
        rxQ.push_back(txdata);
        txBusy = $urandom_range(1, txMax);
      end
    end
  end

  // Read sequence and done monitor.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (memrd && !memwait) begin
        checkOutput("read_addr", 32'(memaddr), 32'(expReadAddr));
        expReadAddr++;
        readCount++;
      end
      if (done) begin
        doneCount++;
        checkOutput("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic startRun(input int maxTx, input bit jitter);
    rxQ.delete();
    doneCount   = 0;
    readCount   = 0;
    expReadAddr = 0;
    txMax       = maxTx;
    txJitter    = jitter;
    for (int a = 2; a < WORDS; a++) mem[a] = 16'($urandom);
    buildExpected();
    @(negedge clk);
    #3;
    start = 1'b1;
    @(negedge clk);
    #3;
    start = 1'b0;
  endtask

  // Full dump: optional extra start while busy, and a start in the done cycle.
  task automatic applyStimulus(input int maxTx, input bit jitter, input bit pokeStart);
    bit timedOut = 1'b1;
    startRun(maxTx, jitter);
    for (int c = 0; c < CYC_LIMIT; c++) begin
      @(negedge clk);
      #3;
      start = pokeStart && (c == 30);
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    start = 1'b1;
    @(negedge clk);
    #3;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("done_timeout", 32'(timedOut), 32'd0);
    checkOutput("idle_after_done", {30'd0, busy, memrd}, 32'd0);
    checkOutput("done_count", 32'(doneCount), 32'd1);
    checkOutput("read_count", 32'(readCount), 32'(WORDS));
    checkOutput("byte_count", 32'(rxQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput($sformatf("byte%0d", i),
                  (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hFFFF_FFFF, 32'(expQ[i]));
    end
  endtask

  initial begin
    mem[0] = 16'h1A2B;
    mem[1] = 16'h00FF;
    for (int a = 2; a < WORDS; a++) mem[a] = 16'($urandom);

    // Reset then idle with no start.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #3;
      checkOutput("idle_outputs", 32'({busy, done, memrd, memaddr, txdata, txstart}), 32'd0);
    end

    // Plain dump with short transmitter busy times.
    applyStimulus(4, 1'b0, 1'b0);

    // Five-cycle memory stall on word 1.
    stallAddr = 1;
    stallLeft = 5;
    applyStimulus(4, 1'b1, 1'b0);
    checkOutput("stall_consumed", 32'(stallLeft), 32'd0);

    // Long random transmitter busy times.
    applyStimulus(600, 1'b1, 1'b0);

    // Start while busy is ignored.
    applyStimulus(8, 1'b1, 1'b1);

    // Reset after the third byte, then a fresh dump from address 0.
    begin
      bit reached = 1'b0;
      startRun(6, 1'b1);
      for (int c = 0; c < CYC_LIMIT; c++) begin
        @(negedge clk);
        #3;
        if (rxQ.size() >= 3) begin
          reached = 1'b1;
          break;
        end
      end
      checkOutput("reached_byte3", 32'(reached), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_abort", 32'({busy, done, memrd, memaddr, txdata, txstart}), 32'd0);
      repeat (2) @(negedge clk);
      #3;
      checkOutput("reset_hold", 32'({busy, done, memrd, memaddr, txdata, txstart}), 32'd0);
      rst_n = 1'b1;
    end
    applyStimulus(4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
